peripheral_dac: RTL
===================

Name: peripheral_dac

Overview:
- Memory-mapped CPU peripheral that drives an external serial (SPI-style) DAC.
- Transmit-side counterpart of the ADC peripheral on the same bus.
- CPU writes a sample word and a start command; the block shifts the sample out MSB-first on a divided serial clock, framed by an active-low sync.
- Exposes busy/done status on the bus. Sits on the CPU peripheral bus beside the ADC peripheral.

Parameters:
- DATA_W, 8: sample width in bits (1..8).
- CLK_DIV, 4: clk_in cycles per serial-clock half-period (>=1).

Ports:
- clk_in  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous active-low reset.
- cs  in  1  peripheral select.
- wr  in  1  bus write strobe; acts when cs && wr.
- rd  in  1  bus read strobe; acts when cs && rd.
- addr  in  4  register address.
- d_in  in  8  bus write data.
- d_out  out  8  bus read data, registered.
- dac_sclk  out  1  serial clock to DAC; idles high.
- dac_din  out  1  serial data to DAC; DAC samples it on dac_sclk falling edge.
- dac_sync_n  out  1  active-low frame select.
- done  out  1  transfer-complete flag; same value as status bit 0.

Behaviour:
- Reset (rst=0, asynchronous): d_out=0, dac_sclk=1, dac_din=0, dac_sync_n=1, done=0, busy=0, data_reg=0, FSM=IDLE, counters=0. A reset mid-transfer aborts it immediately; no partial frame resumes.
- Register map:
  - 0x0 write: data_reg <= d_in[DATA_W-1:0].
  - 0x0 read: zero-extended data_reg.
  - 0x2 write: d_in[0]=1 is a start request.
  - 0x4 read: {6'b0, busy, done}.
  - Other addresses: writes ignored, reads return 0.
- Reads: d_out updates one cycle after the cs && rd cycle. d_out=0 on any cycle without cs && rd.
- Status read at 0x4 clears done on the same edge that registers d_out. The read returns the pre-clear value.
- Start accepted only in IDLE. A start while busy is ignored with no side effects. An accepted start clears done, sets busy, and loads shift_reg <= data_reg.
- Writing data_reg while busy is allowed; it does not affect the frame in flight.
- FSM:
  - IDLE: wait for an accepted start.
  - SHIFT: on the edge after the start, dac_sync_n=0, dac_din=MSB, dac_sclk=1. Each bit holds dac_sclk high for CLK_DIV cycles, then low for CLK_DIV cycles. On each low-to-high sclk transition, the next bit is presented on dac_din. After DATA_W falling edges and the final low half, dac_sclk returns to 1 and the FSM moves to HOLD.
  - HOLD: dac_sync_n=1, dac_din=0 for CLK_DIV cycles; busy stays 1. On exit to IDLE: busy=0, done=1.
- Latency: done asserts 1 + 2*CLK_DIV*DATA_W + CLK_DIV clk_in edges after the start edge.
- Simultaneous events: a start request on the same edge that HOLD exits to IDLE is ignored, because the FSM is not yet IDLE.
- Simultaneous events: a status read on the same edge that done sets returns done=0; done remains set.
- Bit counter wraps only via FSM exit; no more than DATA_W bits are ever shifted per frame.

Optional Feature:
- Macro PERIPHERAL_DAC_AUTOSTART_EN.
- Defined: a write to 0x0 while IDLE also acts as a start, using the newly written value. A write to 0x0 while busy only updates data_reg.
- Undefined: only a write to 0x2 starts a transfer.

Test Plan:
- Reset then read 0x0, 0x4, 0x6 -> d_out = 0x00 each; dac_sync_n=1, dac_sclk=1.
- DATA_W=8, CLK_DIV=2: write 0xA5 to 0x0, write 0x01 to 0x2 -> dac_din sampled at the 8 sclk falling edges = 1,0,1,0,0,1,0,1; dac_sync_n low for exactly 32 cycles; done=1 exactly 35 cycles after the start edge.
- Status during that transfer -> 0x02. After completion: first read returns 0x01, second read returns 0x00.
- During the transfer: write 0x3C to 0x0 and write 0x01 to 0x2 -> current frame still shifts 0xA5; no second frame occurs; a readback of 0x0 returns 0x3C.
- Assert rst low at bit 4 of a frame -> dac_sync_n=1, dac_sclk=1, dac_din=0 asynchronously; status reads 0x00 after release.
- With PERIPHERAL_DAC_AUTOSTART_EN defined: write 0x5A to 0x0 -> frame starts next edge and shifts 0,1,0,1,1,0,1,0.

Source files
------------

// File: rtl/peripheral_dac.sv
// -----------------------------------------------------------------------------
// peripheral_dac
//
// Memory-mapped CPU peripheral that drives an external serial (SPI-style) DAC.
// The CPU writes a sample word and a start command. The block then shifts the
// sample out MSB-first on a divided serial clock, framed by an active-low sync.
// Busy and done status can be read back over the bus.
//
// Register map (addr):
//   0x0  W: data_reg <= d_in[DATA_W-1:0]     R: zero-extended data_reg
//   0x2  W: d_in[0]=1 requests a start       R: 0
//   0x4  W: ignored                          R: {6'b0, busy, done} (clears done)
//   others: writes ignored, reads return 0
//
// Optional feature (macro PERIPHERAL_DAC_AUTOSTART_EN):
//   When defined, a write to 0x0 while IDLE also starts a frame using the
//   newly written value. When undefined, only a write to 0x2 starts a frame.
//
// Parameters:
//   DATA_W   sample width in bits (1..8)
//   CLK_DIV  clk_in cycles per serial-clock half-period (>=1)
//
// Ports:
//   clk_in      system clock, rising edge
//   rst         asynchronous active-low reset
//   cs/wr/rd    bus select, write strobe and read strobe
//   addr        register address
//   d_in        bus write data
//   d_out       registered bus read data (0 when not reading)
//   dac_sclk    serial clock to the DAC, idles high
//   dac_din     serial data; the DAC samples it on the falling sclk edge
//   dac_sync_n  active-low frame select
//   done        transfer-complete flag (mirrors status bit 0)
// -----------------------------------------------------------------------------
module peripheral_dac #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       cs,
    input  logic       wr,
    input  logic       rd,
    input  logic [3:0] addr,
    input  logic [7:0] d_in,
    output logic [7:0] d_out,
    output logic       dac_sclk,
    output logic       dac_din,
    output logic       dac_sync_n,
    output logic       done
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(DATA_W + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } state_t;

    state_t            state;
    state_t            state_next;

    logic              busy;
    logic              busy_next;
    logic              done_next;
    logic [DATA_W-1:0] data_reg;
    logic [DATA_W-1:0] data_next;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_next;
    logic [DIV_W-1:0]  div_cnt;
    logic [DIV_W-1:0]  div_next;
    logic [BIT_W-1:0]  bit_cnt;
    logic [BIT_W-1:0]  bit_next;
    logic              sclk_next;
    logic              din_next;
    logic              sync_next;
    logic [7:0]        d_out_next;

    logic              wr_data;
    logic              wr_ctrl;
    logic              rd_hit;
    logic              start_req;
    logic [DATA_W-1:0] start_value;

    // Bus decode. The start request and the value it loads depend on whether
    // a data write is also allowed to launch a frame.
    always_comb begin
        wr_data = cs && wr && (addr == 4'h0);
        wr_ctrl = cs && wr && (addr == 4'h2);
        rd_hit  = cs && rd;
`ifdef PERIPHERAL_DAC_AUTOSTART_EN
        start_req   = (wr_ctrl && d_in[0]) || wr_data;
        start_value = wr_data ? d_in[DATA_W-1:0] : data_reg;
`else
        start_req   = wr_ctrl && d_in[0];
        start_value = data_reg;
`endif
    end

    // Register file: data_reg may be rewritten at any time because the frame
    // in flight shifts from its own copy. Read data is zero unless a read is
    // strobed; the status value returned is the one before this edge's clear.
    always_comb begin
        data_next  = wr_data ? d_in[DATA_W-1:0] : data_reg;
        d_out_next = 8'h00;
        if (rd_hit) begin
            case (addr)
                4'h0:    d_out_next = 8'(data_reg);
                4'h4:    d_out_next = {6'b0, busy, done};
                default: d_out_next = 8'h00;
            endcase
        end
    end

    // Transfer FSM and serial timing. The first SHIFT cycle (sync still high)
    // opens the frame with the MSB on the line. sclk toggles every CLK_DIV
    // cycles; the falling toggle counts a bit and advances the shift register,
    // and the rising toggle either presents the next bit or, once all DATA_W
    // bits have been clocked, closes the frame into HOLD. A done set on HOLD
    // exit takes priority over a status-read clear on the same edge.
    always_comb begin
        state_next = state;
        busy_next  = busy;
        done_next  = done;
        shift_next = shift_reg;
        div_next   = div_cnt;
        bit_next   = bit_cnt;
        sclk_next  = dac_sclk;
        din_next   = dac_din;
        sync_next  = dac_sync_n;

        if (rd_hit && (addr == 4'h4)) begin
            done_next = 1'b0;
        end

        case (state)
            IDLE: begin
                if (start_req) begin
                    state_next = SHIFT;
                    busy_next  = 1'b1;
                    done_next  = 1'b0;
                    shift_next = start_value;
                    div_next   = '0;
                    bit_next   = '0;
                end
            end

            SHIFT: begin
                if (dac_sync_n) begin
                    sync_next = 1'b0;
                    sclk_next = 1'b1;
                    din_next  = shift_reg[DATA_W-1];
                    div_next  = '0;
                end else if (div_cnt != DIV_LAST) begin
                    div_next = div_cnt + DIV_W'(1);
                end else begin
                    div_next = '0;
                    if (dac_sclk) begin
                        sclk_next  = 1'b0;
                        bit_next   = bit_cnt + BIT_W'(1);
                        shift_next = shift_reg << 1;
                    end else if (bit_cnt == BIT_LAST) begin
                        state_next = HOLD;
                        sclk_next  = 1'b1;
                        sync_next  = 1'b1;
                        din_next   = 1'b0;
                    end else begin
                        sclk_next = 1'b1;
                        din_next  = shift_reg[DATA_W-1];
                    end
                end
            end

            HOLD: begin
                if (div_cnt != DIV_LAST) begin
                    div_next = div_cnt + DIV_W'(1);
                end else begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    div_next   = '0;
                    bit_next   = '0;
                end
            end

            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
                sclk_next  = 1'b1;
                sync_next  = 1'b1;
                din_next   = 1'b0;
                div_next   = '0;
                bit_next   = '0;
            end
        endcase
    end

    // State register. Reset aborts any frame in progress and parks the DAC
    // lines in their idle levels.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            data_reg   <= '0;
            shift_reg  <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            dac_sclk   <= 1'b1;
            dac_din    <= 1'b0;
            dac_sync_n <= 1'b1;
            d_out      <= 8'h00;
        end else begin
            state      <= state_next;
            busy       <= busy_next;
            done       <= done_next;
            data_reg   <= data_next;
            shift_reg  <= shift_next;
            div_cnt    <= div_next;
            bit_cnt    <= bit_next;
            dac_sclk   <= sclk_next;
            dac_din    <= din_next;
            dac_sync_n <= sync_next;
            d_out      <= d_out_next;
        end
    end

endmodule
